// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: pipeline constants and the fetch-stage state encoding.
package rv32i_pkg;

    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
    localparam int          PC_STEP     = 4;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: owns the PC, fetches over a req/ack handshake, and
// feeds decode with registered instruction, valid and PC, inserting bubbles as needed.
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] inst,
    output logic             inst_valid,
    output logic [WIDTH-1:0] pc_out
);

    localparam logic [WIDTH-1:0] STEP   = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_INST);

    fetch_state_t     state, state_d;
    logic [WIDTH-1:0] pc, pc_d;
    logic [WIDTH-1:0] drain_addr, drain_addr_d;
    logic [WIDTH-1:0] hold_word, hold_word_d;
    logic [WIDTH-1:0] hold_pc, hold_pc_d;
    logic [WIDTH-1:0] inst_d, pc_out_d;
    logic             inst_valid_d;
    logic [WIDTH-1:0] target;

    assign target = {redirect_pc[WIDTH-1:2], 2'b00};

    // Memory-facing outputs depend only on registered state (plus the reset gate).
    always_comb begin
        imem_req  = !reset && (state != HOLD);
        imem_addr = pc;
        if (reset) begin
            imem_addr = RESET_PC;
        end else if (state == DRAIN) begin
            imem_addr = drain_addr;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state;
        pc_d         = pc;
        drain_addr_d = drain_addr;
        hold_word_d  = hold_word;
        hold_pc_d    = hold_pc;
        inst_d       = BUBBLE;
        inst_valid_d = 1'b0;
        pc_out_d     = '0;

        case (state)
            REQ: begin
                if (redirect) begin
                    pc_d = target;
                    if (!imem_ack) begin
                        // Request still in flight: keep presenting its address until it drains.
                        drain_addr_d = pc;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        hold_word_d = imem_rdata;
                        hold_pc_d   = pc;
                        state_d     = HOLD;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_valid_d = 1'b1;
                        pc_out_d     = pc;
                        pc_d         = pc + STEP;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (!stall) begin
                    inst_d       = hold_word;
                    inst_valid_d = 1'b1;
                    pc_out_d     = hold_pc;
                    pc_d         = hold_pc + STEP;
                    state_d      = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REQ;
            pc         <= RESET_PC;
            inst       <= BUBBLE;
            inst_valid <= 1'b0;
            pc_out     <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            inst       <= inst_d;
            inst_valid <= inst_valid_d;
            pc_out     <= pc_out_d;
        end
    end

    // NOTE: drain/hold buffers are plain datapath, only read once the FSM has loaded them, so they carry no reset.
    always_ff @(posedge clk) begin
        drain_addr <= drain_addr_d;
        hold_word  <= hold_word_d;
        hold_pc    <= hold_pc_d;
    end

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed table-driven bench for rv32i_fetch: one vector per cycle, plus reset sequences.
module tb_rv32i_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    // Inputs applied during a cycle, and outputs expected to be visible in that same cycle.
    typedef struct {
        logic        ack;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ack, input logic stl, input logic rd,
                                input logic [31:0] rpc, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_inst,
                                input logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.stall = stl; v.redirect = rd; v.rpc = rpc; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc);
        check({tag, " imem_req"},   {31'd0, imem_req},   {31'd0, e_req});
        check({tag, " imem_addr"},  imem_addr,           e_addr);
        check({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
        check({tag, " inst"},       inst,                e_inst);
        check({tag, " pc_out"},     pc_out,              e_pc);
    endtask

    task automatic drive(input logic ack, input logic stl, input logic rd,
                         input logic [31:0] rpc, input logic [31:0] rdata);
        imem_ack    = ack;
        stall       = stl;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rdata  = rdata;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        //              ack stl rd  rpc           rdata         req addr          vld inst          pc
        // zero-wait: one instruction per cycle
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hA5A5_0000, 1, 32'h0000_0000, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hA5A5_0004, 1, 32'h0000_0004, 1, 32'hA5A5_0000, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hA5A5_0008, 1, 32'h0000_0008, 1, 32'hA5A5_0004, 32'h4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hA5A5_000C, 1, 32'h0000_000C, 1, 32'hA5A5_0008, 32'h8));
        // 3-cycle wait at 0x10, ack arrives together with stall
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0010, 1, 32'hA5A5_000C, 32'hC));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0010, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0010, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'hA5A5_0010, 1, 32'h0000_0010, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,         0, 32'h0000_0010, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,         0, 32'h0000_0010, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         0, 32'h0000_0010, 0, 32'h0,         32'h0));
        // released: held word for 0x10 out, next request at 0x14 with a 3-cycle wait
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0014, 1, 32'hA5A5_0010, 32'h10));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0014, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0014, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hA5A5_0014, 1, 32'h0000_0014, 0, 32'h0,         32'h0));
        // redirect to 0x103 with 0x18 outstanding: drain, discard, refetch at 0x100
        vecs.push_back(mk(0, 0, 1, 32'h0000_0103, 32'h0,        1, 32'h0000_0018, 1, 32'hA5A5_0014, 32'h14));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0018, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0018, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hA5A5_0100, 1, 32'h0000_0100, 0, 32'h0,         32'h0));
        // stall into HOLD at 0x104, then redirect+stall: held word dropped
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'hA5A5_0104, 1, 32'h0000_0104, 1, 32'hA5A5_0100, 32'h100));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0200, 32'h0,        0, 32'h0000_0104, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0200, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hA5A5_0200, 1, 32'h0000_0200, 0, 32'h0,         32'h0));
        // redirect with ack in the same cycle: data discarded, stay in REQ; target bits [1:0] ignored
        vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFE, 32'h1234_5678, 1, 32'h0000_0204, 1, 32'hA5A5_0200, 32'h200));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h5A5A_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0));
        // PC wraps to 0; two redirects while draining, the last one wins
        vecs.push_back(mk(0, 0, 1, 32'h0000_0300, 32'h0,        1, 32'h0000_0000, 1, 32'h5A5A_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0400, 32'h0,        1, 32'h0000_0000, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h1111_1111, 1, 32'h0000_0000, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hA5A5_0400, 1, 32'h0000_0400, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         1, 32'h0000_0404, 1, 32'hA5A5_0400, 32'h400));

        // Reset: request gated immediately, registered outputs cleared at the edge.
        @(negedge clk);
        #1;
        check("reset imem_req", {31'd0, imem_req}, 32'd0);
        check("reset imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        #1;
        check_outputs("after reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].ack, vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].rdata);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc);
        end

        // Reset mid-wait at 0x404 while a valid word is on inst.
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("midreset imem_req", {31'd0, imem_req}, 32'd0);
        check("midreset imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        #1;
        check_outputs("midreset cleared", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5_0000);
        #1;
        check_outputs("post-reset req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_outputs("post-reset fetch", 1'b1, 32'h4, 1'b1, 32'hA5A5_0000, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
